// File: rtl/mt_compute_core.sv
// mt_compute_core: multi-threaded compute core.
// Runs NUM_THREADS hardware threads. Each thread has its own PC, a 16-entry register file
// and a compare flag. The core issues at most one instruction per cycle and picks the thread
// round-robin. Instruction fetch is combinational. Data memory uses a single outstanding
// request/response unit, so a load or store stalls only the thread that issued it.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           one-cycle pulse that moves the core from IDLE to RUN
//   imem_addr       PC of the thread selected this cycle (combinational)
//   imem_data       instruction at imem_addr, same cycle
//   dmem_req_*      data request channel: valid, ready, we, addr, wdata
//   dmem_rsp_*      load response: one-cycle valid plus rdata
//   issue_valid     an instruction issued at the last edge (debug)
//   issue_tid       thread of that instruction
//   busy / done     core is in RUN / core is in DONE
//
// Request handshake: dmem_req_valid is a registered output. Once it is raised, valid and
// we/addr/wdata stay constant until a rising edge sees valid && ready. That edge is the
// transfer. A store then completes. A load waits for one dmem_rsp_valid pulse, which is
// only accepted while the unit is waiting for a response.
module mt_compute_core #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_data,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic                  issue_valid,
  output logic [TID_W-1:0]      issue_tid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE}        core_state_t;
  typedef enum logic [1:0] {T_READY, T_WAIT_MEM, T_HALTED} thr_state_t;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT_RSP}    mem_state_t;

  core_state_t           core_state, core_next;
  mem_state_t            mem_state, mem_next;
  thr_state_t            thr_state [NUM_THREADS];
  logic [ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [DATA_WIDTH-1:0] regs [NUM_THREADS][16];
  logic [NUM_THREADS-1:0] cmp_flag;
  logic [TID_W-1:0]      rr_ptr;
  logic [TID_W-1:0]      mem_tid;
  logic [3:0]            mem_rd;

  // Scheduler: the first READY thread at or after rr_ptr. It only issues in RUN.
  logic             sel_found;
  logic [TID_W-1:0] sel_tid;
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = rr_ptr;
    for (int k = 0; k < NUM_THREADS; k++) begin
      if (!sel_found && thr_state[(int'(rr_ptr) + k) % NUM_THREADS] == T_READY) begin
        sel_found = 1'b1;
        sel_tid   = TID_W'((int'(rr_ptr) + k) % NUM_THREADS);
      end
    end
    if (core_state != C_RUN) sel_found = 1'b0;
  end

  logic all_halted;
  always_comb begin
    all_halted = 1'b1;
    for (int t = 0; t < NUM_THREADS; t++)
      if (thr_state[t] != T_HALTED) all_halted = 1'b0;
  end

  // Decode of the fetched instruction. The imm field overlaps the rs1/rs2 fields.
  logic [3:0]            op, rd_f, rs1_f, rs2_f;
  logic [7:0]            imm;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, rd_val, imm_data;
  logic [ADDR_WIDTH-1:0] imm_addr, pc_inc;
  logic                  is_mem, can_issue, issue_mem;

  assign imem_addr = pc[sel_tid];
  assign op        = imem_data[15:12];
  assign rd_f      = imem_data[11:8];
  assign rs1_f     = imem_data[7:4];
  assign rs2_f     = imem_data[3:0];
  assign imm       = imem_data[7:0];
  assign rs1_val   = regs[sel_tid][rs1_f];
  assign rs2_val   = regs[sel_tid][rs2_f];
  assign rd_val    = regs[sel_tid][rd_f];
  assign imm_data  = DATA_WIDTH'(imm);
  assign imm_addr  = ADDR_WIDTH'(imm);
  assign pc_inc    = pc[sel_tid] + 1'b1;
  assign is_mem    = (op == 4'h9) || (op == 4'hA);
  // A memory op that finds the unit busy does not issue. The pointer still moves past it.
  assign can_issue = sel_found && (!is_mem || mem_state == M_IDLE);
  assign issue_mem = can_issue && is_mem;

  assign busy           = (core_state == C_RUN);
  assign done           = (core_state == C_DONE);
  assign dmem_req_valid = (mem_state == M_REQ);

  // Core FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) core_state <= C_IDLE;
    else       core_state <= core_next;
  end

  always_comb begin
    core_next = core_state;
    case (core_state)
      C_IDLE:  if (start) core_next = C_RUN;
      C_RUN:   if (all_halted && mem_state == M_IDLE) core_next = C_DONE;
      default: core_next = core_state;
    endcase
  end

  // Memory unit FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_state <= M_IDLE;
    else       mem_state <= mem_next;
  end

  always_comb begin
    mem_next = mem_state;
    case (mem_state)
      M_IDLE:     if (issue_mem) mem_next = M_REQ;
      M_REQ:      if (dmem_req_ready) mem_next = dmem_req_we ? M_IDLE : M_WAIT_RSP;
      M_WAIT_RSP: if (dmem_rsp_valid) mem_next = M_IDLE;
      default:    mem_next = M_IDLE;
    endcase
  end

  // Thread state, register files, PCs and request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t]        <= '0;
        thr_state[t] <= T_READY;
        for (int r = 0; r < 16; r++)
          regs[t][r] <= (r == 15) ? DATA_WIDTH'(t) : '0;
      end
      cmp_flag       <= '0;
      rr_ptr         <= '0;
      mem_tid        <= '0;
      mem_rd         <= '0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      issue_valid    <= 1'b0;
      issue_tid      <= '0;
    end else begin
      issue_valid <= 1'b0;

      // The owning thread is in WAIT_MEM, so it is never the issuing thread below.
      if (mem_state == M_REQ && dmem_req_ready && dmem_req_we)
        thr_state[mem_tid] <= T_READY;
      if (mem_state == M_WAIT_RSP && dmem_rsp_valid) begin
        regs[mem_tid][mem_rd] <= dmem_rsp_rdata;
        thr_state[mem_tid]    <= T_READY;
      end

      if (sel_found)
        rr_ptr <= (sel_tid == TID_W'(NUM_THREADS - 1)) ? '0 : sel_tid + 1'b1;

      if (can_issue) begin
        issue_valid  <= 1'b1;
        issue_tid    <= sel_tid;
        pc[sel_tid]  <= pc_inc;
        case (op)
          4'h1: regs[sel_tid][rd_f] <= rs1_val + rs2_val;
          4'h2: regs[sel_tid][rd_f] <= rs1_val - rs2_val;
          4'h3: regs[sel_tid][rd_f] <= rs1_val * rs2_val;
          4'h4: regs[sel_tid][rd_f] <= rd_val + imm_data;
          4'h5: regs[sel_tid][rd_f] <= rd_val - imm_data;
          4'h6: cmp_flag[sel_tid]   <= (rs1_val < rs2_val);
          4'h7: pc[sel_tid]         <= imm_addr;
          4'h8: if (cmp_flag[sel_tid]) pc[sel_tid] <= imm_addr;
          4'h9, 4'hA: begin
            dmem_req_we        <= (op == 4'hA);
            dmem_req_addr      <= imm_addr;
            dmem_req_wdata     <= rd_val;
            mem_rd             <= rd_f;
            mem_tid            <= sel_tid;
            thr_state[sel_tid] <= T_WAIT_MEM;
          end
          4'hF: begin
            pc[sel_tid]        <= pc[sel_tid];
            thr_state[sel_tid] <= T_HALTED;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
